wb_port_arbiter: RTL

Shares the register file's single write port among three writeback requesters: load data, ALU result, and misc/link. Grants one requester per cycle and registers the winner onto the register file write signals (`reg3_write`, `reg3_addr`, `reg3_bus`). Keeps a 16-bit pending-write scoreboard so decode can stall on registers whose writes are still in flight. Sits between the execute/memory stages and the register file.

---
 rtl/spartan_cpu_pkg.sv | 13 +
 rtl/wb_rr_picker.sv | 22 ++
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/spartan_cpu_pkg.sv
// Shared CPU constants: datapath widths, register count
// and writeback requester indices.
package spartan_cpu_pkg;

    localparam int WORD_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    localparam int WB_LOAD = 0;
    localparam int WB_ALU  = 1;
    localparam int WB_MISC = 2;

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin one-hot picker for the three writeback requesters.
// Priority starts at ptr and wraps mod 3.
module wb_rr_picker (
    input  logic [2:0] valid,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    int idx;

    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = 0; k < 3; k++) begin
            idx = (int'(ptr) + k) % 3;
            if (grant == 3'b000 && valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register file write-port arbiter with pending-write scoreboard.
// Define WB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module wb_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*WORD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        claim_valid,
    input  logic [ADDR_W-1:0]           claim_addr,
    output logic                        reg3_write,
    output logic [ADDR_W-1:0]           reg3_addr,
    output logic [WORD_W-1:0]           reg3_bus,
    output logic [(1<<ADDR_W)-1:0]      pending
);

    import spartan_cpu_pkg::*;

    logic [2:0]                 pick;
    logic [1:0]                 win_idx;
    logic [ADDR_W-1:0]          win_addr;
    logic [WORD_W-1:0]          win_data;
    logic [(1<<ADDR_W)-1:0]     pend_nxt;

`ifdef WB_ROUND_ROBIN_EN
    logic [1:0] ptr;

    wb_rr_picker u_picker (
        .valid (req_valid[2:0]),
        .ptr   (ptr),
        .grant (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (|req_ready) begin
            ptr <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
        end
    end
`else
    always_comb begin
        pick = '0;
        if (req_valid[WB_LOAD]) begin
            pick[WB_LOAD] = 1'b1;
        end else if (req_valid[WB_ALU]) begin
            pick[WB_ALU] = 1'b1;
        end else if (req_valid[WB_MISC]) begin
            pick[WB_MISC] = 1'b1;
        end
    end
`endif

    // No grants while in reset so nothing transfers into a flushed pipe.
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            req_ready = pick;
        end
    end

    always_comb begin
        unique case (1'b1)
            req_ready[WB_ALU]:  win_idx = 2'd1;
            req_ready[WB_MISC]: win_idx = 2'd2;
            default:            win_idx = 2'd0;
        endcase
    end

    assign win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_data = req_data[win_idx*WORD_W +: WORD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            reg3_write <= 1'b0;
            reg3_addr  <= '0;
            reg3_bus   <= '0;
        end else begin
            reg3_write <= |req_ready;
            if (|req_ready) begin
                reg3_addr <= win_addr;
                reg3_bus  <= win_data;
            end
        end
    end

    // Claim is applied after the clear: a fresh claim is a younger write.
    always_comb begin
        pend_nxt = pending;
        if (reg3_write) begin
            pend_nxt[reg3_addr] = 1'b0;
        end
        if (claim_valid) begin
            pend_nxt[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

endmodule
